// File: rtl/seq_mul.sv
// seq_mul: sequential shift-add multiplier, one partial product per clock.
// Signed operands are handled by multiplying magnitudes and negating the
// final product when the operand signs differ.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;    // magnitude of x, shifted left one place per step
    logic [WIDTH-1:0]     mplier;   // magnitude of y, shifted right one place per step
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     mag_x;
    logic [WIDTH-1:0]     mag_y;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;

    // Operand magnitudes and product sign for the operation being accepted;
    // the most negative value maps to 2**(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_x  = (sgn && x[WIDTH-1]) ? -x : x;
        mag_y  = (sgn && y[WIDTH-1]) ? -y : y;
        neg_in = sgn & (x[WIDTH-1] ^ y[WIDTH-1]);
    end

    // Accumulator after the current step and the signed-corrected result.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        result   = neg ? -acc_next : acc_next;
    end

    // Control FSM and datapath registers with registered busy/done/p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_x};
                        mplier <= mag_y;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= neg_in;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        p     <= result;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and randomized checks of seq_mul at WIDTH 8, 2, 4, 16.
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  st = '0;
    logic        sg = 1'b0;
    logic [31:0] xa = '0;
    logic [31:0] ya = '0;

    logic        b8, d8, b2, d2, b4, d4, b16, d16;
    logic [15:0] p8;
    logic [3:0]  p2;
    logic [7:0]  p4;
    logic [31:0] p16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sgn(sg),
        .x(xa[7:0]), .y(ya[7:0]), .busy(b8), .done(d8), .p(p8));
    seq_mul #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sgn(sg),
        .x(xa[1:0]), .y(ya[1:0]), .busy(b2), .done(d2), .p(p2));
    seq_mul #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sgn(sg),
        .x(xa[3:0]), .y(ya[3:0]), .busy(b4), .done(d4), .p(p4));
    seq_mul #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .sgn(sg),
        .x(xa[15:0]), .y(ya[15:0]), .busy(b16), .done(d16), .p(p16));

    function automatic int wid(input int i);
        case (i)
            0: return 8;
            1: return 2;
            2: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic logic dsel(input int i);
        case (i)
            0: return d8;
            1: return d2;
            2: return d4;
            default: return d16;
        endcase
    endfunction

    function automatic logic bsel(input int i);
        case (i)
            0: return b8;
            1: return b2;
            2: return b4;
            default: return b16;
        endcase
    endfunction

    function automatic logic [63:0] psel(input int i);
        case (i)
            0: return 64'(p8);
            1: return 64'(p2);
            2: return 64'(p4);
            default: return 64'(p16);
        endcase
    endfunction

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input bit s,
                                             input logic [31:0] a, input logic [31:0] b);
        longint av, bv, pr;
        longint lim;
        lim = longint'(64'd1 << w);
        av = longint'(64'(a)) % lim;
        bv = longint'(64'(b)) % lim;
        if (s && av >= lim / 2) av = av - lim;
        if (s && bv >= lim / 2) bv = bv - lim;
        pr = av * bv;
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One isolated operation on DUT idx: checks latency, busy span, product, single-cycle done.
    task automatic mul(input int idx, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
        int  w;
        int  lat;
        bit  busy_ok;
        w = wid(idx);
        @(negedge clk);
        sg = s; xa = a; ya = b; st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
        lat = 0;
        busy_ok = bsel(idx) && !dsel(idx);
        for (int k = 1; k <= w + 4; k++) begin
            @(negedge clk);
            if (dsel(idx)) begin
                lat = k;
                break;
            end
            if (!bsel(idx)) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(w));
        chk({tag, "_busy"}, 64'(busy_ok && !bsel(idx)), 64'd1);
        chk({tag, "_p"}, psel(idx), exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(dsel(idx)), 64'd0);
    endtask

    logic [63:0] expq[$];
    logic [63:0] e;
    logic [31:0] ra, rb;
    bit          rs;
    bit          seen_done;

    initial begin
        // Reset and idle with no start
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            bit idle_ok;
            idle_ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (p8 !== 16'h0 || b8 !== 1'b0 || d8 !== 1'b0) idle_ok = 1'b0;
            end
            chk("reset_idle", 64'(idle_ok), 64'd1);
        end

        // Unsigned corners
        mul(0, 1'b0, 32'd255, 32'd255, 64'hFE01, "u_255x255");
        mul(0, 1'b0, 32'd0,   32'd200, 64'h0000, "u_0x200");
        mul(0, 1'b0, 32'd1,   32'd1,   64'h0001, "u_1x1");

        // Signed corners
        mul(0, 1'b1, 32'h80, 32'h80, 64'h4000, "s_m128xm128");
        mul(0, 1'b1, 32'h80, 32'h7F, 64'hC080, "s_m128x127");
        mul(0, 1'b1, 32'hFF, 32'h01, 64'hFFFF, "s_m1x1");
        mul(0, 1'b1, 32'h05, 32'hFD, 64'hFFF1, "s_5xm3");

        // Back-to-back with start held high; operands change every cycle and
        // only those present at sampling edges 0, 9, 18 may affect results.
        @(negedge clk);
        st[0] = 1'b1;
        for (int c = 0; c < 27; c++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            sg = rs; xa = ra; ya = rb;
            if (c % 9 == 0) expq.push_back(ref_prod(8, rs, ra, rb));
            @(negedge clk);
            chk("b2b_done", 64'(d8), 64'(c % 9 == 8));
            if (d8 && expq.size() > 0) begin
                e = expq.pop_front();
                chk("b2b_p", 64'(p8), e);
            end
        end
        st[0] = 1'b0;
        chk("b2b_all_results", 64'(expq.size()), 64'd0);
        @(negedge clk);

        // Make p nonzero, then abort a 100*100 with reset mid-operation
        mul(0, 1'b0, 32'd9, 32'd9, 64'd81, "pre_abort");
        @(negedge clk);
        sg = 1'b0; xa = 32'd100; ya = 32'd100; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_p", 64'(p8), 64'd0);
        chk("abort_busy_done", 64'({b8, d8}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d8 || b8) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        mul(0, 1'b0, 32'd3, 32'd7, 64'd21, "post_abort_3x7");

        // Randomized sweep across all widths and both modes
        for (int di = 0; di < 4; di++) begin
            for (int n = 0; n < 10; n++) begin
                int w;
                w = wid(di);
                rs = 1'($urandom_range(0, 1));
                ra = $urandom & 32'((64'd1 << w) - 64'd1);
                rb = $urandom & 32'((64'd1 << w) - 64'd1);
                mul(di, rs, ra, rb, ref_prod(w, rs, ra, rb), $sformatf("sweep_w%0d", w));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
